// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RISC-V multi-cycle control path.
// Contents:
//   - opcode / funct3 / funct7 constants for the supported subset
//   - ALU operation codes, shared by the ALU, the controller and the benches
//   - the controller state enum and the decoded instruction class enum
//   - f3_alu_op: maps a funct3 field to {valid, alu_cc} for the ALU ops
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1100;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R_TYPE = 3'd1,
        CLS_I_ALU  = 3'd2,
        CLS_LW     = 3'd3,
        CLS_SW     = 3'd4
    } inst_class_t;

    // Bit 4 of the result says whether funct3 names a supported ALU op.
    // The funct3=000 case always returns ADD; R-type SUB is resolved by
    // the caller from funct7.
    function automatic logic [4:0] f3_alu_op(input logic [2:0] funct3);
        case (funct3)
            F3_ADD:  return {1'b1, ALU_ADD};
            F3_XOR:  return {1'b1, ALU_XOR};
            F3_OR:   return {1'b1, ALU_OR};
            F3_AND:  return {1'b1, ALU_AND};
            F3_SLT:  return {1'b1, ALU_SLT};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: purely combinational instruction classifier.
// Ports:
//   opcode     in  7  instruction[6:0]
//   funct7     in  7  instruction[31:25]
//   funct3     in  3  instruction[14:12]
//   inst_class out    decoded instruction class (CLS_NONE when illegal opcode)
//   alu_cc     out 4  ALU operation for this instruction
//   illegal    out 1  encoding is not supported
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    output inst_class_t inst_class,
    output logic [3:0]  alu_cc,
    output logic        illegal
);

    logic [4:0] op;

    // I-type funct7 bits belong to the immediate, so they are never
    // examined there; that is also why an I-type can never become SUB.
    always_comb begin
        op         = f3_alu_op(funct3);
        inst_class = CLS_NONE;
        alu_cc     = ALU_ADD;
        illegal    = 1'b0;
        case (opcode)
            OP_R_TYPE: begin
                inst_class = CLS_R_TYPE;
                if (funct3 == F3_ADD) begin
                    if (funct7 == F7_BASE) begin
                        alu_cc = ALU_ADD;
                    end else if (funct7 == F7_ALT) begin
                        alu_cc = ALU_SUB;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    alu_cc  = op[3:0];
                    illegal = !op[4] || (funct7 != F7_BASE);
                end
            end
            OP_I_ALU: begin
                inst_class = CLS_I_ALU;
                alu_cc     = op[3:0];
                illegal    = !op[4];
            end
            OP_LW: begin
                inst_class = CLS_LW;
                illegal    = (funct3 != F3_WORD);
            end
            OP_SW: begin
                inst_class = CLS_SW;
                illegal    = (funct3 != F3_WORD);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle control FSM for the RISC-V data_path.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB), waits on the
// data-memory ready handshake, traps unsupported encodings and memory
// timeouts, and counts retired instructions.
// Parameters:
//   MEM_WAIT_MAX  cycles allowed in MEM without mem_ready before trapping
//   CNT_W         width of retire_count
// Ports:
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   opcode, funct7, funct3      decoded fields from the datapath IR
//   mem_ready                   data memory finished the current access
//   ir_write, pc_write          load IR / advance PC (FETCH)
//   reg_write, mem2reg          register write enable / writeback mux select
//   alu_src, alu_cc             immediate operand select / ALU operation
//   mem_read, mem_write         data-memory strobes
//   illegal                     sticky trap flag
//   retire_count                number of completed instructions (wraps)
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem2reg,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       alu_cc,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_count
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t            state;
    state_t            state_next;
    inst_class_t       cls_q;
    logic [3:0]        alu_cc_q;
    logic [WAIT_W-1:0] wait_cnt;

    inst_class_t       dec_class;
    logic [3:0]        dec_cc;
    logic              dec_illegal;

    logic              retire;
    logic              mem_timeout;
    logic              use_imm;

    alu_decoder u_alu_decoder (
        .opcode     (opcode),
        .funct7     (funct7),
        .funct3     (funct3),
        .inst_class (dec_class),
        .alu_cc     (dec_cc),
        .illegal    (dec_illegal)
    );

    // wait_cnt counts completed MEM cycles, so the MEM_WAIT_MAX-th cycle is
    // the one that sees MAX-1; mem_ready is checked first and so wins a tie.
    assign mem_timeout = (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));
    assign use_imm     = (cls_q == CLS_I_ALU) || (cls_q == CLS_LW) || (cls_q == CLS_SW);

    // State register, latched decode, MEM wait counter and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            cls_q        <= CLS_NONE;
            alu_cc_q     <= ALU_ADD;
            wait_cnt     <= '0;
            retire_count <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                cls_q    <= dec_class;
                alu_cc_q <= dec_cc;
            end
            if ((state == MEM) && (state_next == MEM)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (retire) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

    // Next state and Moore outputs. Outputs depend only on the state and
    // the latched decode; reset masks them so a MEM access is dropped in
    // the same cycle reset is raised.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem2reg    = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_cc     = 4'b0000;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                state_next = dec_illegal ? TRAP : EXECUTE;
            end
            EXECUTE: begin
                alu_cc     = alu_cc_q;
                alu_src    = use_imm;
                state_next = ((cls_q == CLS_LW) || (cls_q == CLS_SW)) ? MEM : WB;
            end
            MEM: begin
                alu_cc    = alu_cc_q;
                alu_src   = use_imm;
                mem_read  = (cls_q == CLS_LW);
                mem_write = (cls_q == CLS_SW);
                if (mem_ready) begin
                    if (cls_q == CLS_SW) begin
                        state_next = FETCH;
                        retire     = 1'b1;
                    end else begin
                        state_next = WB;
                    end
                end else if (mem_timeout) begin
                    state_next = TRAP;
                end
            end
            WB: begin
                alu_cc     = alu_cc_q;
                alu_src    = use_imm;
                reg_write  = 1'b1;
                mem2reg    = (cls_q == CLS_LW);
                state_next = FETCH;
                retire     = 1'b1;
            end
            TRAP: begin
                illegal    = 1'b1;
                state_next = TRAP;
            end
            default: begin
                state_next = TRAP;
            end
        endcase
        if (reset) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem2reg   = 1'b0;
            alu_src   = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            alu_cc    = 4'b0000;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Each instruction is expanded into per-cycle stimulus and the per-cycle
// outputs the controller must show; both go into queues and are popped
// together as the clock runs.
module tb_multicycle_controller;
    import rv_ctrl_pkg::*;

    localparam int MEM_WAIT_MAX = 15;
    localparam int CNT_W        = 4;

    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_ILL = 3;

    // Strobe vector layout: {ir_write, pc_write, reg_write, mem2reg, alu_src, mem_read, mem_write}
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_FETCH = 7'b1100000;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic [6:0]       opcode    = 7'd0;
    logic [6:0]       funct7    = 7'd0;
    logic [2:0]       funct3    = 3'd0;
    logic             mem_ready = 1'b0;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             mem2reg;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic [3:0]       alu_cc;
    logic             illegal;
    logic [CNT_W-1:0] retire_count;

    typedef struct {
        string      tag;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       rdy;
        logic       rst;
    } stim_t;

    stim_t       stimQ[$];
    logic [43:0] expQ[$];

    int compCount = 0;
    int failCount = 0;

    logic [CNT_W-1:0] expRetire = '0;
    logic [6:0]       curOpc = 7'd0;
    logic [6:0]       curF7  = 7'd0;
    logic [2:0]       curF3  = 3'd0;

    multicycle_controller #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct7       (funct7),
        .funct3       (funct3),
        .mem_ready    (mem_ready),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .mem2reg      (mem2reg),
        .alu_src      (alu_src),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .alu_cc       (alu_cc),
        .illegal      (illegal),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [43:0] got, input logic [43:0] exp);
        compCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got strobes=%b cc=%b ill=%b ret=%0d, expected strobes=%b cc=%b ill=%b ret=%0d",
                     tag, got[43:37], got[36:33], got[32], got[31:0],
                     exp[43:37], exp[36:33], exp[32], exp[31:0]);
        end
    endtask

    task automatic pushCycle(input string tag, input logic rdy, input logic rst,
                             input logic [6:0] str, input logic [3:0] cc, input logic ill);
        stim_t s;
        s.tag = tag;
        s.opc = curOpc;
        s.f7  = curF7;
        s.f3  = curF3;
        s.rdy = rdy;
        s.rst = rst;
        stimQ.push_back(s);
        expQ.push_back({str, cc, ill, 32'(expRetire)});
    endtask

    task automatic resetCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            pushCycle($sformatf("%s/reset%0d", tag, i), 1'($urandom_range(0, 1)), 1'b1, S_NONE, 4'b0000, 1'b0);
            expRetire = '0;
        end
    endtask

    task automatic trapCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            pushCycle($sformatf("%s/trap%0d", tag, i), 1'($urandom_range(0, 1)), 1'b0, S_NONE, 4'b0000, 1'b1);
        end
    endtask

    // w = extra MEM cycles before mem_ready (-1: never ready).
    // abortAt >= 0 raises reset on that MEM cycle.
    task automatic applyStimulus(input string tag, input logic [6:0] opc, input logic [6:0] f7,
                                 input logic [2:0] f3, input int kind, input logic [3:0] cc,
                                 input int w, input int abortAt);
        logic       src;
        logic [6:0] memStr;
        logic [6:0] wbStr;
        int         n;
        curOpc = opc;
        curF7  = f7;
        curF3  = f3;
        src    = (kind == K_LW) || (kind == K_SW) || (opc == OP_I_ALU);
        pushCycle({tag, "/fetch"}, 1'($urandom_range(0, 1)), 1'b0, S_FETCH, 4'b0000, 1'b0);
        pushCycle({tag, "/decode"}, 1'($urandom_range(0, 1)), 1'b0, S_NONE, 4'b0000, 1'b0);
        if (kind == K_ILL) begin
            trapCycles(tag, 3);
            resetCycles(tag, 2);
            return;
        end
        pushCycle({tag, "/exec"}, 1'($urandom_range(0, 1)), 1'b0, {4'b0000, src, 2'b00}, cc, 1'b0);
        if ((kind == K_LW) || (kind == K_SW)) begin
            memStr = (kind == K_LW) ? 7'b0000110 : 7'b0000101;
            n = (w < 0) ? MEM_WAIT_MAX : w + 1;
            for (int i = 0; i < n; i++) begin
                if (abortAt == i) begin
                    pushCycle($sformatf("%s/memreset%0d", tag, i), 1'b0, 1'b1, S_NONE, 4'b0000, 1'b0);
                    expRetire = '0;
                    return;
                end
                pushCycle($sformatf("%s/mem%0d", tag, i), (w >= 0) && (i == w), 1'b0, memStr, cc, 1'b0);
            end
            if (w < 0) begin
                trapCycles(tag, 3);
                resetCycles(tag, 2);
                return;
            end
            if (kind == K_SW) begin
                expRetire = expRetire + 1'b1;
                return;
            end
        end
        wbStr = (kind == K_LW) ? 7'b0011100 : {2'b00, 1'b1, 1'b0, src, 2'b00};
        pushCycle({tag, "/wb"}, 1'($urandom_range(0, 1)), 1'b0, wbStr, cc, 1'b0);
        expRetire = expRetire + 1'b1;
    endtask

    task automatic runQueue();
        stim_t       s;
        logic [43:0] e;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            opcode    = s.opc;
            funct7    = s.f7;
            funct3    = s.f3;
            mem_ready = s.rdy;
            reset     = s.rst;
            #1;
            checkOutput(s.tag,
                        {ir_write, pc_write, reg_write, mem2reg, alu_src, mem_read, mem_write,
                         alu_cc, illegal, 32'(retire_count)},
                        e);
            @(posedge clk);
            #1;
        end
    endtask

    logic [2:0] f3Tab[5] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b010};
    logic [3:0] ccTab[5] = '{4'b0010, 4'b1100, 4'b0001, 4'b0000, 4'b0111};

    initial begin
        @(posedge clk);
        #1;
        resetCycles("init", 3);

        applyStimulus("add",   OP_R_TYPE, 7'b0000000, 3'b000, K_ALU, 4'b0010, 0, -1);
        applyStimulus("sub",   OP_R_TYPE, 7'b0100000, 3'b000, K_ALU, 4'b0110, 0, -1);
        applyStimulus("ior",   OP_I_ALU,  7'b0100000, 3'b110, K_ALU, 4'b0001, 0, -1);
        applyStimulus("iadd",  OP_I_ALU,  7'b0100000, 3'b000, K_ALU, 4'b0010, 0, -1);
        applyStimulus("rxor",  OP_R_TYPE, 7'b0000000, 3'b100, K_ALU, 4'b1100, 0, -1);
        applyStimulus("rand",  OP_R_TYPE, 7'b0000000, 3'b111, K_ALU, 4'b0000, 0, -1);
        applyStimulus("rslt",  OP_R_TYPE, 7'b0000000, 3'b010, K_ALU, 4'b0111, 0, -1);
        applyStimulus("islt",  OP_I_ALU,  7'b1111111, 3'b010, K_ALU, 4'b0111, 0, -1);
        applyStimulus("ixor",  OP_I_ALU,  7'b0000001, 3'b100, K_ALU, 4'b1100, 0, -1);
        applyStimulus("lw2",   OP_LW,     7'b0000000, 3'b010, K_LW,  4'b0010, 2, -1);
        applyStimulus("lw0",   OP_LW,     7'b1010101, 3'b010, K_LW,  4'b0010, 0, -1);
        applyStimulus("sw0",   OP_SW,     7'b0000000, 3'b010, K_SW,  4'b0010, 0, -1);
        applyStimulus("sw3",   OP_SW,     7'b0110000, 3'b010, K_SW,  4'b0010, 3, -1);
        applyStimulus("lwlast", OP_LW,    7'b0000000, 3'b010, K_LW,  4'b0010, MEM_WAIT_MAX - 1, -1);
        applyStimulus("illop", 7'b1100011, 7'b0000000, 3'b000, K_ILL, 4'b0000, 0, -1);

        applyStimulus("add2",  OP_R_TYPE, 7'b0000000, 3'b000, K_ALU, 4'b0010, 0, -1);
        applyStimulus("badf7", OP_R_TYPE, 7'b0100000, 3'b100, K_ILL, 4'b0000, 0, -1);
        applyStimulus("badf7a", OP_R_TYPE, 7'b0000001, 3'b000, K_ILL, 4'b0000, 0, -1);
        applyStimulus("rf3",   OP_R_TYPE, 7'b0000000, 3'b001, K_ILL, 4'b0000, 0, -1);
        applyStimulus("if3",   OP_I_ALU,  7'b0000000, 3'b101, K_ILL, 4'b0000, 0, -1);
        applyStimulus("lwf3",  OP_LW,     7'b0000000, 3'b000, K_ILL, 4'b0000, 0, -1);
        applyStimulus("swf3",  OP_SW,     7'b0000000, 3'b001, K_ILL, 4'b0000, 0, -1);
        applyStimulus("swto",  OP_SW,     7'b0000000, 3'b010, K_SW,  4'b0010, -1, -1);

        applyStimulus("pre1",  OP_I_ALU,  7'b0000000, 3'b111, K_ALU, 4'b0000, 0, -1);
        applyStimulus("pre2",  OP_SW,     7'b0000000, 3'b010, K_SW,  4'b0010, 1, -1);
        applyStimulus("lwrst", OP_LW,     7'b0000000, 3'b010, K_LW,  4'b0010, -1, 2);

        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("wrap%0d", i), OP_R_TYPE, 7'b0000000, f3Tab[i % 5], K_ALU,
                          ccTab[i % 5], 0, -1);
        end

        runQueue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

- Multi-cycle control FSM for the RISC-V `data_path` block; it sits on the other side of the datapath's control interface.
- It consumes the decoded fields `opcode`, `funct7` and `funct3` from the instruction register.
- It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath control strobe.
- It also waits on a data-memory ready handshake, traps unsupported encodings and counts retired instructions.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: maximum cycles spent in MEM waiting for `mem_ready` before trapping.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: one clock domain; reset is synchronous and active-high.
- `opcode` in 7: instruction[6:0] from the datapath IR.
- `funct7` in 7: instruction[31:25].
- `funct3` in 3: instruction[14:12].
- `mem_ready` in 1: data memory has completed the current read or write.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: PC ← PC+4.
- `reg_write` out 1: register-file write enable.
- `mem2reg` out 1: writeback mux selects memory data.
- `alu_src` out 1: ALU operand B is the immediate.
- `mem_read` out 1: data-memory read strobe.
- `mem_write` out 1: data-memory write strobe.
- `alu_cc` out 4: ALU operation code.
- `illegal` out 1: sticky trap flag.
- `retire_count` out CNT_W: number of instructions completed.

## Operation
Opcode classes:
- R_TYPE `0110011`
- I_ALU `0010011`
- LW `0000011`, with funct3 `010`
- SW `0100011`, with funct3 `010`
- Anything else is illegal.

ALU codes:
- ADD `0010`, SUB `0110`, XOR `1100`, OR `0001`, AND `0000`, SLT `0111`.

alu_cc decode by class:
- R_TYPE, funct3=000: funct7=`0000000` gives ADD; funct7=`0100000` gives SUB; any other funct7 is illegal.
- R_TYPE, funct3 100/110/111/010: gives XOR/OR/AND/SLT; funct7 must be `0000000`, otherwise illegal.
- I_ALU: funct3 000/100/110/111/010 gives ADD/XOR/OR/AND/SLT.
- I_ALU ignores funct7, because those bits are immediate. An I_ALU instruction never yields SUB.
- LW/SW: always ADD.
- Any other funct3 is illegal.

Decode registers:
- Class and alu_cc are latched at the end of DECODE.
- All outputs are Moore functions of the state and these latched registers; none depends directly on the inputs.

FSM states (3-bit): FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- FETCH: `ir_write=1`, `pc_write=1`. Next state is DECODE.
- DECODE: latch decode. Illegal → TRAP; otherwise → EXECUTE.
- EXECUTE: drive `alu_cc`. `alu_src=1` for I_ALU, LW and SW. R_TYPE/I_ALU → WB; LW/SW → MEM.
- MEM: assert `mem_read` (LW) or `mem_write` (SW) and hold it every cycle until `mem_ready`.
  - On `mem_ready`: LW → WB; SW → FETCH, with retire.
  - Wait counter reaches MEM_WAIT_MAX without `mem_ready` → TRAP.
- WB: `reg_write=1`; `mem2reg=1` for LW only. Then → FETCH, with retire.
- TRAP: all strobes 0, `illegal=1`. The FSM stays here until `reset`.

`alu_cc` and `alu_src` are held from EXECUTE through MEM and WB, so the address and result stay stable; they read 0 in FETCH, DECODE and TRAP.

`retire_count` increments on the cycle leaving WB or leaving MEM for SW. It wraps modulo 2^CNT_W.

## Timing
Reset values:
- While `reset` is high, every strobe is forced to 0 combinationally.
- On the reset edge: state=FETCH, `illegal=0`, `retire_count=0`, decode registers = ADD/none, wait counter=0.
- Reset mid-MEM drops `mem_read`/`mem_write` in the same cycle.

Latency (CPI):
- R_TYPE/I_ALU: 4 cycles.
- SW: 4+w cycles.
- LW: 5+w cycles.
- w is the number of extra MEM cycles. `mem_ready` high on the first MEM cycle gives w=0.

Handshake rules:
- `mem_ready` is sampled only in MEM and ignored in every other state.
- If `mem_ready` arrives on the same cycle the wait counter hits MEM_WAIT_MAX, `mem_ready` wins.

Instruction register: `ir_write` is asserted for exactly one cycle per instruction, so `opcode`/`funct*` are valid from DECODE onward.

## Structure
Shared package `rv_ctrl_pkg` contains:
- opcode constants;
- the ALU code constants, reused by the ALU and the testbenches;
- the state enum.

One natural sub-module is `alu_decoder`: combinational class + alu_cc + illegal from opcode/funct7/funct3. The FSM, wait counter and retire counter stay in the top.

## Test plan
- **ADD, then SUB:** R_TYPE funct3=000, funct7=0 → EXECUTE `alu_cc=0010`, WB `reg_write=1`, `mem2reg=0`; funct7=`0100000` → `alu_cc=0110`. `retire_count` steps 0→1→2 on cycles 4 and 8.
- **I_ALU OR:** funct3=110, funct7=`0100000` → `alu_cc=0001` (not SUB), `alu_src=1`, 4 cycles.
- **LW with wait states:** `mem_ready` is low for 2 MEM cycles → `mem_read` is high for 3 cycles, then WB has `mem2reg=1`, `reg_write=1`; total 7 cycles.
- **SW timeout:** `mem_ready` never asserts → `mem_write` is high for MEM_WAIT_MAX cycles, then TRAP with `illegal=1`, all strobes 0.
- **Illegal opcode:** opcode `1100011` → TRAP directly after DECODE; `retire_count` unchanged.
- **Reset mid-MEM:** reset asserted during an LW → strobes 0 in the same cycle; the next cycle is FETCH with `ir_write=1` and `retire_count=0`.
